// File: rtl/fp_div_normalize_round.sv
// Purpose: normalizes an iterative divider's quotient, rounds it to nearest-even and packs an IEEE-754 single.
// Latency: 3 cycles counted from and including the capture edge, plus 1 per left shift; worst case WIDTH+1.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module fp_div_normalize_round #(
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] r_in,
    input  logic [9:0]       exp_in,
    input  logic             sign_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow,
    output logic             inexact,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               sticky_q, sticky_d;
    logic signed [10:0] exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               zero_q, zero_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inx_q, inx_d;

    // Rounding datapath; only meaningful once the quotient is normalized.
    logic [22:0]        mant;
    logic               guard;
    logic               rest;
    logic               round_up;
    logic [23:0]        mant_sum;
    logic signed [10:0] exp_rnd;

    // Round-to-nearest-even on the normalized quotient; carry-out bumps the exponent.
    always_comb begin
        mant     = quo_q[WIDTH-3:WIDTH-25];
        guard    = quo_q[WIDTH-26];
        rest     = (|quo_q[WIDTH-27:0]) | sticky_q;
        round_up = guard & (rest | mant[0]);
        mant_sum = {1'b0, mant} + {23'd0, round_up};
        exp_rnd  = exp_q + {10'd0, mant_sum[23]};
    end

    // Next-state and datapath updates; one normalization shift per cycle.
    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    quo_d    = q_in;
                    sticky_d = |r_in;
                    exp_d    = {exp_in[9], exp_in};
                    sign_d   = sign_in;
                    zero_d   = 1'b0;
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (quo_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = ROUND;
                end else if (quo_q[WIDTH-1]) begin
                    quo_d    = quo_q >> 1;
                    sticky_d = sticky_q | quo_q[0];
                    exp_d    = exp_q + 11'sd1;
                    state_d  = ROUND;
                end else if (quo_q[WIDTH-2]) begin
                    state_d = ROUND;
                end else begin
                    quo_d = quo_q << 1;
                    exp_d = exp_q - 11'sd1;
                end
            end
            ROUND: begin
                state_d = DONE;
                if (zero_q) begin
                    result_d = {sign_q, 31'h0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                end else if (exp_rnd >= 11'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                    inx_d    = 1'b1;
                end else if (exp_rnd <= 11'sd0) begin
                    // No denormals: anything below the normal range flushes to zero.
                    result_d = {sign_q, 31'h0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd[7:0], mant_sum[22:0]};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = guard | rest;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            quo_q    <= '0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_div_normalize_round.sv
// Directed checks of normalize/round/pack with WIDTH=30.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Latency is counted in rising edges from and including the capture edge.
module tb_fp_div_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] q_in, r_in;
    logic [9:0]  exp_in;
    logic        sign_in, in_valid, in_ready;
    logic [31:0] result;
    logic        overflow, underflow, inexact;
    logic        out_valid, out_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_div_normalize_round #(.WIDTH(30)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .r_in      (r_in),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Presents one operand set for a single cycle and waits (bounded) for out_valid.
    task automatic send(input logic [29:0] q, input logic [29:0] r, input logic [9:0] e,
                        input logic s, output int lat);
        @(negedge clk);
        q_in = q; r_in = r; exp_in = e; sign_in = s; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Sends one vector and checks latency, result and {overflow,underflow,inexact}.
    task automatic vec(input string tag, input logic [29:0] q, input logic [29:0] r,
                       input logic [9:0] e, input logic s, input int exp_lat,
                       input logic [31:0] exp_res, input logic [2:0] exp_flg);
        int lat;
        send(q, r, e, s, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flg"}, {29'd0, overflow, underflow, inexact}, {29'd0, exp_flg});
        take();
    endtask

    initial begin
        logic [31:0] held;
        int lat;
        rst = 1'b1; q_in = '0; r_in = '0; exp_in = '0; sign_in = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'd0, overflow, underflow, inexact}, 32'd0);

        vec("one",      30'h10000000, 30'd0, 10'd127, 1'b0, 3, 32'h3F800000, 3'b000);
        vec("half",     30'h08000000, 30'd0, 10'd127, 1'b0, 4, 32'h3F000000, 3'b000);
        vec("two",      30'h20000000, 30'd0, 10'd127, 1'b0, 3, 32'h40000000, 3'b000);
        vec("tie_even", 30'h10000010, 30'd0, 10'd127, 1'b0, 3, 32'h3F800000, 3'b001);
        vec("tie_stk",  30'h10000010, 30'd1, 10'd127, 1'b0, 3, 32'h3F800001, 3'b001);
        vec("carry",    30'h1FFFFFF1, 30'd0, 10'd127, 1'b0, 3, 32'h40000000, 3'b001);
        vec("ovf",      30'h10000000, 30'd0, 10'd255, 1'b0, 3, 32'h7F800000, 3'b101);
        vec("unf",      30'h10000000, 30'd0, 10'd0,   1'b1, 3, 32'h80000000, 3'b011);
        vec("zero",     30'h0,        30'd5, 10'd127, 1'b1, 3, 32'h80000000, 3'b000);
        // Only bit 0 set: WIDTH-2 left shifts, 2^-28 -> exponent 99.
        vec("worst",    30'h00000001, 30'd0, 10'd127, 1'b0, 31, 32'h31800000, 3'b000);

        // Output must hold while the consumer stalls.
        send(30'h08000000, 30'd0, 10'd127, 1'b0, lat);
        check("hold_lat", 32'(lat), 32'd4);
        held = 32'h3F000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_res", result, held);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        take();
        check("after_take_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a long normalization.
        @(negedge clk);
        q_in = 30'h00000001; r_in = '0; exp_in = 10'd127; sign_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("mid_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_result", result, 32'h0);
        repeat (35) begin @(posedge clk); @(negedge clk); end
        check("mid_rst_discard", {31'd0, out_valid}, 32'd0);

        // Reset wins over a simultaneous transfer.
        rst = 1'b1; in_valid = 1'b1; q_in = 30'h10000000; exp_in = 10'd127;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_vs_valid_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        check("rst_vs_valid_no_out", {31'd0, out_valid}, 32'd0);

        // Still functional afterwards.
        vec("post", 30'h20000000, 30'd0, 10'd100, 1'b1, 3, 32'hB2800000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_div_normalize_round.md
FP_DIV_NORMALIZE_ROUND -- requirements
Module: fp_div_normalize_round

Interface
REQ-001 SHALL have parameter WIDTH, default 30, giving the quotient/remainder width of the upstream iterative divider; legal range 27..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port q_in, input, WIDTH, the divider quotient, unsigned fixed-point, value = q_in / 2^(WIDTH-2).
REQ-005 SHALL have port r_in, input, WIDTH, the divider remainder; only "nonzero" is used, as sticky.
REQ-006 SHALL have port exp_in, input, 10, signed two's-complement biased exponent (ea - eb + 127).
REQ-007 SHALL have port sign_in, input, 1, the result sign (sa ^ sb).
REQ-008 SHALL have port in_valid, input, 1, and port in_ready, output, 1; a transfer occurs when both are high on a clock edge.
REQ-009 SHALL have port result, output, 32, the packed IEEE-754 single result.
REQ-010 SHALL have ports overflow, underflow and inexact, each output, 1, the result flags.
REQ-011 SHALL have port out_valid, output, 1, and port out_ready, input, 1; the result is consumed when both are high on a clock edge.

Function
REQ-012 SHALL implement an FSM with states IDLE, NORM, ROUND and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; on a transfer it SHALL capture q, sticky=|r_in, exp sign-extended to 11 bits, and sign, then go to NORM.
REQ-014 In NORM, when q==0, the block SHALL set a zero flag and go to ROUND.
REQ-015 In NORM, when q[WIDTH-1]==1, the block SHALL shift q right one bit, OR the shifted-out bit into sticky, increment exp, and go to ROUND.
REQ-016 In NORM, when q[WIDTH-2]==1 (and q[WIDTH-1]==0), the block SHALL go to ROUND.
REQ-017 In NORM, otherwise, the block SHALL shift q left one bit, decrement exp, and stay in NORM; only one shift SHALL occur per cycle.
REQ-018 The mantissa SHALL be q[WIDTH-3:WIDTH-25], the guard bit q[WIDTH-26], and rest = |q[WIDTH-27:0] | sticky.
REQ-019 ROUND SHALL apply round-to-nearest-even: increment when guard & (rest | mantissa LSB).
REQ-020 When the increment carries out of the mantissa, the mantissa SHALL be 0 and exp SHALL be incremented.
REQ-021 After rounding, the block SHALL set inexact = guard | rest.
REQ-022 After rounding, when exp >= 255, result SHALL be {sign, 8'hFF, 23'h0} with overflow=1 and inexact=1.
REQ-023 After rounding, when exp <= 0 (and q is nonzero), result SHALL be {sign, 31'h0} with underflow=1 and inexact=1 (flush to zero, no denormals).
REQ-024 When the zero flag is set, result SHALL be {sign, 31'h0} with all flags 0.
REQ-025 ROUND SHALL register result and flags and go to DONE in one cycle.
REQ-026 In DONE, out_valid SHALL be 1 and result/flags SHALL stay stable until out_ready=1, then the block SHALL return to IDLE.
REQ-027 The block SHALL NOT accept new input while not in IDLE.
REQ-028 Latency SHALL be 3 cycles from the capture edge to out_valid high when no left shift is needed, plus 1 cycle per left shift; the worst case is WIDTH+1.
REQ-029 All exponent arithmetic SHALL be 11-bit signed, with no wrap-around.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL go to IDLE regardless of state, including mid-NORM or DONE, and in-flight data SHALL be discarded.
REQ-031 Reset values SHALL be: out_valid=0, in_ready=1 after the reset edge, result=0, overflow=underflow=inexact=0.
REQ-032 When rst and in_valid are high at the same edge, reset SHALL win and no capture SHALL occur.

Verification (WIDTH=30)
REQ-033 Stimulus q=0x10000000, r=0, exp=127, sign=0 -> result 0x3F800000, no flags, out_valid 3 cycles after capture.
REQ-034 Stimulus q=0x08000000, exp=127 -> result 0x3F000000 with latency 4; stimulus q=0x20000000, exp=127 -> result 0x40000000 with latency 3.
REQ-035 Stimulus q=0x10000010, r=0 -> result 0x3F800000, inexact=1 (tie to even); the same q with r=1 -> result 0x3F800001, inexact=1.
REQ-036 Stimulus q=0x10000000 with exp=255 -> result 0x7F800000, overflow=1; with exp=0 and sign=1 -> result 0x80000000, underflow=1; stimulus q=0 -> signed zero, no flags.
REQ-037 Hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout; assert rst mid-NORM -> the next cycle shows out_valid=0 and in_ready=1.
